// File: rtl/mem_access_unit.sv
// Load/store-side memory access unit: passes ALU results through to MEM/WB and
// runs naturally aligned loads against a ready/valid data memory with alignment checking.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result_i,
    input  logic [31:0] result_address_i,
    input  logic [4:0]  rd_i,
    input  logic        wb_en_i,
    input  logic        read_en_i,
    input  logic [2:0]  mem_op_i,
    output logic        dmem_req_o,
    output logic [31:0] dmem_addr_o,
    input  logic        dmem_ready_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        wb_en_o,
    output logic [4:0]  rd_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_lat_q, rd_lat_d;
    logic        wb_lat_q, wb_lat_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic        req_s;
    logic        stall_s;

    // op[1:0]==00 is a byte access, 01 a halfword, anything else a word.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        logic bad;
        case (op[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

    // op[2] selects zero extension for the byte/halfword forms.
    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lo,
                                            input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = rdata[8*lo +: 8];
        half_v = rdata[16*lo[1] +: 16];
        case (op)
            3'b000:  res = {{24{byte_v[7]}}, byte_v};
            3'b001:  res = {{16{half_v[15]}}, half_v};
            3'b100:  res = {24'h000000, byte_v};
            3'b101:  res = {16'h0000, half_v};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Next-state, latch and write-back decisions.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        op_d       = op_q;
        rd_lat_d   = rd_lat_q;
        wb_lat_d   = wb_lat_q;
        wb_en_d    = 1'b0;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        req_s      = 1'b0;
        stall_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read_en_i) begin
                    if (is_misaligned(mem_op_i, result_address_i[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d   = result_address_i;
                        op_d     = mem_op_i;
                        rd_lat_d = rd_i;
                        wb_lat_d = wb_en_i;
                        stall_s  = 1'b1;
                        state_d  = S_REQ;
                    end
                end else begin
                    wb_data_d = result_i;
                    rd_d      = rd_i;
                    wb_en_d   = wb_en_i & (rd_i != 5'd0);
                end
            end
            S_REQ: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
                if (dmem_ready_i) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                // Stall drops in the completion cycle so upstream can advance on this edge.
                if (dmem_rvalid_i) begin
                    wb_data_d = extract(op_q, addr_q[1:0], dmem_rdata_i);
                    rd_d      = rd_lat_q;
                    wb_en_d   = wb_lat_q & (rd_lat_q != 5'd0);
                    state_d   = S_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'h0000_0000;
            op_q       <= 3'b000;
            rd_lat_q   <= 5'd0;
            wb_lat_q   <= 1'b0;
            wb_en_q    <= 1'b0;
            rd_q       <= 5'd0;
            wb_data_q  <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            rd_lat_q   <= rd_lat_d;
            wb_lat_q   <= wb_lat_d;
            wb_en_q    <= wb_en_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_req_o  = req_s;
    assign dmem_addr_o = {addr_q[31:2], 2'b00};
    assign stall_o     = stall_s;
    assign wb_en_o     = wb_en_q;
    assign rd_o        = rd_q;
    assign wb_data_o   = wb_data_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an arithmetic load model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result_i, result_address_i, dmem_rdata_i;
    logic [4:0]  rd_i;
    logic        wb_en_i, read_en_i, dmem_ready_i, dmem_rvalid_i;
    logic [2:0]  mem_op_i;
    logic        dmem_req_o, stall_o, wb_en_o, misalign_o;
    logic [31:0] dmem_addr_o, wb_data_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .result_i(result_i), .result_address_i(result_address_i),
        .rd_i(rd_i), .wb_en_i(wb_en_i), .read_en_i(read_en_i), .mem_op_i(mem_op_i),
        .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .wb_en_o(wb_en_o), .rd_o(rd_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes for a load type.
    function automatic int size_of(input logic [2:0] op);
        if (op == 3'b000 || op == 3'b100) return 1;
        if (op == 3'b001 || op == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] op, input logic [31:0] addr);
        return (addr % size_of(op)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> (8 * (addr % 4))) % 256;
        h = (rdata >> (16 * ((addr / 2) % 2))) % 65536;
        case (op)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return rdata;
        endcase
    endfunction

    // Called at a negedge; ends at the negedge where the pass-through result is visible.
    task automatic do_pass(input logic [31:0] res, input logic [4:0] rd, input logic wb,
                           input logic spurious_rvalid);
        read_en_i = 1'b0; result_i = res; rd_i = rd; wb_en_i = wb;
        dmem_rvalid_i = spurious_rvalid; dmem_rdata_i = $urandom;
        #1;
        chk("pass_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        chk("pass_data", wb_data_o, res);
        chk("pass_rd", {27'd0, rd_o}, {27'd0, rd});
        chk("pass_wben", {31'd0, wb_en_o}, {31'd0, wb & (rd != 5'd0)});
        chk("pass_misalign", {31'd0, misalign_o}, 32'd0);
        chk("pass_req", {31'd0, dmem_req_o}, 32'd0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input logic [4:0] rd,
                           input logic wb, input int rdly, input int vdly,
                           input logic [31:0] rdata);
        logic [31:0] prev_data;
        logic [4:0]  prev_rd;
        prev_data = wb_data_o; prev_rd = rd_o;
        read_en_i = 1'b1; result_address_i = addr; mem_op_i = op; rd_i = rd; wb_en_i = wb;
        result_i = $urandom;
        #1;
        if (model_misaligned(op, addr)) begin
            chk("mis_stall", {31'd0, stall_o}, 32'd0);
            @(negedge clk);
            chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
            chk("mis_wben", {31'd0, wb_en_o}, 32'd0);
            chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
            chk("mis_data_held", wb_data_o, prev_data);
        end else begin
            chk("ld_stall0", {31'd0, stall_o}, 32'd1);
            for (int c = 0; c <= rdly; c++) begin
                @(negedge clk);
                chk("req_req", {31'd0, dmem_req_o}, 32'd1);
                chk("req_addr", dmem_addr_o, addr - (addr % 4));
                chk("req_stall", {31'd0, stall_o}, 32'd1);
                chk("req_wben", {31'd0, wb_en_o}, 32'd0);
                dmem_ready_i = (c == rdly);
            end
            for (int c = 0; c <= vdly; c++) begin
                @(negedge clk);
                dmem_ready_i = 1'b0;
                chk("wait_req", {31'd0, dmem_req_o}, 32'd0);
                chk("wait_wben", {31'd0, wb_en_o}, 32'd0);
                chk("wait_rd_held", {27'd0, rd_o}, {27'd0, prev_rd});
                dmem_rvalid_i = (c == vdly);
                dmem_rdata_i = (c == vdly) ? rdata : $urandom;
                #1;
                chk("wait_stall", {31'd0, stall_o}, {31'd0, c != vdly});
            end
            @(negedge clk);
            dmem_rvalid_i = 1'b0;
            chk("ld_data", wb_data_o, model_load(op, addr, rdata));
            chk("ld_rd", {27'd0, rd_o}, {27'd0, rd});
            chk("ld_wben", {31'd0, wb_en_o}, {31'd0, wb & (rd != 5'd0)});
            chk("ld_req", {31'd0, dmem_req_o}, 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, {31'd0, dmem_req_o}, 32'd0);
        chk({tag, "_addr"}, dmem_addr_o, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        chk({tag, "_wben"}, {31'd0, wb_en_o}, 32'd0);
        chk({tag, "_rd"}, {27'd0, rd_o}, 32'd0);
        chk({tag, "_data"}, wb_data_o, 32'd0);
        chk({tag, "_mis"}, {31'd0, misalign_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; result_i = 32'd0; result_address_i = 32'd0; rd_i = 5'd0; wb_en_i = 1'b0;
        read_en_i = 1'b0; mem_op_i = 3'd0; dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
        dmem_rdata_i = 32'd0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_pass(32'h1234_5678, 5'd5, 1'b1, 1'b0);
        do_load(32'h0000_0103, 3'b000, 5'd7, 1'b1, 0, 0, 32'h80FF_0000);
        do_load(32'h0000_0022, 3'b101, 5'd9, 1'b1, 3, 2, 32'hBEEF_1234);
        do_load(32'h0000_0041, 3'b010, 5'd3, 1'b1, 0, 0, 32'h0);
        do_pass(32'hCAFE_0001, 5'd4, 1'b1, 1'b0);
        do_load(32'h0000_0080, 3'b010, 5'd0, 1'b1, 1, 1, 32'hDEAD_BEEF);
        do_pass(32'h0000_00AA, 5'd6, 1'b0, 1'b1);
        do_load(32'h0000_0043, 3'b001, 5'd2, 1'b1, 0, 0, 32'h0);
        do_load(32'h0000_0042, 3'b110, 5'd2, 1'b1, 0, 0, 32'h0);
        do_load(32'h0000_0046, 3'b001, 5'd8, 1'b1, 0, 0, 32'h8001_7FFF);
        do_load(32'h0000_0101, 3'b100, 5'd8, 1'b1, 0, 0, 32'h0000_F000);

        // Reset while waiting for read data; the late rvalid must be ignored.
        read_en_i = 1'b1; result_address_i = 32'h0000_0200; mem_op_i = 3'b010;
        rd_i = 5'd11; wb_en_i = 1'b1; dmem_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dmem_ready_i = 1'b0;
        read_en_i = 1'b0; result_i = 32'd0; rd_i = 5'd0; wb_en_i = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        @(negedge clk);
        rst = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        chk_all_zero("rst_late");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_pass($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            end else begin
                do_load($urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                        1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
